// File: rtl/comb_lock_ctrl.sv
// Keypad combination lock: configurable code length, retry lockout, auto-relock on door/timeout.
// Define COMBLOCK_SETCODE_EN to allow changing the code at runtime (SET while open).
module comb_lock_ctrl #(
  parameter int CODE_LEN = 4,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYC = 50_000_000,
  parameter int UNLOCK_CYC = 25_000_000,
  parameter logic [4*CODE_LEN-1:0] RESET_CODE = 'h1234
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  newKey,
  input  logic [4:0]            keyCode,
  input  logic                  switch,
  output logic                  unlock,
  output logic                  eLED,
  output logic                  lockout,
  output logic [4*CODE_LEN-1:0] dispVal,
  output logic [CODE_LEN-1:0]   radixVal
);

  localparam int EW = 4 * CODE_LEN;
  localparam int CW = $clog2(CODE_LEN + 1);
  localparam int TRW = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (LOCKOUT_CYC > UNLOCK_CYC) ? LOCKOUT_CYC : UNLOCK_CYC;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [CW-1:0]  CNT_FULL = CW'(CODE_LEN);
  localparam logic [TRW-1:0] TRIES_MAX = TRW'(MAX_TRIES);
  localparam logic [TW-1:0]  LOCKOUT_LAST = TW'(LOCKOUT_CYC - 1);
  localparam logic [TW-1:0]  UNLOCK_LAST = TW'(UNLOCK_CYC - 1);

  typedef enum logic [2:0] {
    LOCKED,
    ERROR,
    LOCKOUT,
    OPEN
`ifdef COMBLOCK_SETCODE_EN
    , SETCODE
`endif
  } stateT;

  stateT state, stateNext;

  logic [EW-1:0]  entry, entryNext, entryShift;
  logic [CW-1:0]  cnt, cntNext;
  logic [TRW-1:0] tries, triesNext, triesInc;
  logic [TW-1:0]  timer, timerNext;
  logic           opened, openedNext;
  logic [EW-1:0]  code;
`ifdef COMBLOCK_SETCODE_EN
  logic [EW-1:0]  codeNext;
  logic           isSet;
`endif

  logic isDigit, isEnter, isClear, doorRelock;
  logic unlockNext, eLedNext, lockoutNext;
  logic [EW-1:0] dispNext;
  logic [CODE_LEN-1:0] radixNext;

  assign isDigit = newKey && !keyCode[4];
  assign isEnter = newKey && (keyCode == 5'h10);
  assign isClear = newKey && (keyCode == 5'h11);
`ifdef COMBLOCK_SETCODE_EN
  assign isSet = newKey && (keyCode == 5'h12);
`else
  assign code = RESET_CODE;
`endif

  // New digit enters on the right; the oldest digit falls off the top.
  assign entryShift = EW'({entry, keyCode[3:0]});
  assign triesInc = (tries == TRIES_MAX) ? tries : tries + TRW'(1);
  assign doorRelock = switch && (opened || timer == UNLOCK_LAST);

  always_comb begin
    stateNext = state;
    entryNext = entry;
    cntNext = cnt;
    triesNext = tries;
    timerNext = timer;
    openedNext = opened;
`ifdef COMBLOCK_SETCODE_EN
    codeNext = code;
`endif
    unique case (state)
      LOCKED: begin
        if (isDigit && cnt != CNT_FULL) begin
          entryNext = entryShift;
          cntNext = cnt + CW'(1);
        end else if (isClear) begin
          entryNext = '0;
          cntNext = '0;
        end else if (isEnter) begin
          entryNext = '0;
          cntNext = '0;
          if (cnt == CNT_FULL && entry == code) begin
            stateNext = OPEN;
            triesNext = '0;
            timerNext = '0;
            openedNext = 1'b0;
          end else begin
            triesNext = triesInc;
            if (triesInc == TRIES_MAX) begin
              stateNext = LOCKOUT;
              timerNext = '0;
            end else begin
              stateNext = ERROR;
            end
          end
        end
      end
      ERROR: begin
        if (newKey) stateNext = LOCKED;
      end
      LOCKOUT: begin
        if (timer == LOCKOUT_LAST) begin
          stateNext = LOCKED;
          triesNext = '0;
        end else begin
          timerNext = timer + TW'(1);
        end
      end
      OPEN: begin
        // Door activity and timeout outrank any key arriving in the same cycle.
        if (!switch) openedNext = 1'b1;
        if (doorRelock) begin
          stateNext = LOCKED;
        end else begin
          if (switch) timerNext = timer + TW'(1);
          if (isEnter && switch) begin
            stateNext = LOCKED;
          end
`ifdef COMBLOCK_SETCODE_EN
          else if (isSet) begin
            stateNext = SETCODE;
            entryNext = '0;
            cntNext = '0;
          end
`endif
        end
      end
`ifdef COMBLOCK_SETCODE_EN
      SETCODE: begin
        if (isDigit && cnt != CNT_FULL) begin
          entryNext = entryShift;
          cntNext = cnt + CW'(1);
        end else if (isClear) begin
          entryNext = '0;
          cntNext = '0;
        end else if (isEnter && cnt == CNT_FULL) begin
          codeNext = entry;
          stateNext = OPEN;
          entryNext = '0;
          cntNext = '0;
        end else if (isSet) begin
          stateNext = OPEN;
          entryNext = '0;
          cntNext = '0;
        end
      end
`endif
      default: stateNext = LOCKED;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    unlockNext = 1'b0;
    eLedNext = 1'b0;
    lockoutNext = 1'b0;
    dispNext = entryNext;
    radixNext = '0;
    unique case (stateNext)
      LOCKED: begin
        for (int i = 0; i < CODE_LEN; i++) radixNext[i] = (i < int'(cntNext));
      end
`ifdef COMBLOCK_SETCODE_EN
      SETCODE: begin
        unlockNext = 1'b1;
        for (int i = 0; i < CODE_LEN; i++) radixNext[i] = (i < int'(cntNext));
      end
`endif
      OPEN: begin
        unlockNext = 1'b1;
        dispNext = '0;
        radixNext = '1;
      end
      ERROR: begin
        eLedNext = 1'b1;
        dispNext = {CODE_LEN{4'hE}};
      end
      LOCKOUT: begin
        eLedNext = 1'b1;
        lockoutNext = 1'b1;
        dispNext = {CODE_LEN{4'hE}};
      end
      default: dispNext = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LOCKED;
      entry <= '0;
      cnt <= '0;
      tries <= '0;
      timer <= '0;
      opened <= 1'b0;
`ifdef COMBLOCK_SETCODE_EN
      code <= RESET_CODE;
`endif
      unlock <= 1'b0;
      eLED <= 1'b0;
      lockout <= 1'b0;
      dispVal <= '0;
      radixVal <= '0;
    end else begin
      state <= stateNext;
      entry <= entryNext;
      cnt <= cntNext;
      tries <= triesNext;
      timer <= timerNext;
      opened <= openedNext;
`ifdef COMBLOCK_SETCODE_EN
      code <= codeNext;
`endif
      unlock <= unlockNext;
      eLED <= eLedNext;
      lockout <= lockoutNext;
      dispVal <= dispNext;
      radixVal <= radixNext;
    end
  end

endmodule

// File: tb/tb_comb_lock_ctrl.sv
// Self-checking bench for comb_lock_ctrl: vector table plus hand-written door, lockout and code sequences.
`timescale 1ns/1ps
module tb_comb_lock_ctrl;

  localparam int CODE_LEN = 4;
  localparam int MAX_TRIES = 3;
  localparam int LOCKOUT_CYC = 20;
  localparam int UNLOCK_CYC = 12;
  localparam logic [4:0] K_ENTER = 5'h10;
  localparam logic [4:0] K_CLEAR = 5'h11;
  localparam logic [4:0] K_SET = 5'h12;

  logic clock = 1'b0;
  logic reset, newKey, switch;
  logic [4:0] keyCode;
  logic unlock, eLED, lockout;
  logic [15:0] dispVal;
  logic [3:0] radixVal;

  typedef struct packed {
    logic u;
    logic e;
    logic lo;
    logic [15:0] dv;
    logic [3:0] rv;
  } expT;

  typedef struct {
    logic rst;
    logic nk;
    logic [4:0] kc;
    logic sw;
    expT e;
  } vecT;

  vecT vecs[$];
  expT expQ[$];
  int compared = 0;
  int mismatched = 0;
  int stepId = 0;

  comb_lock_ctrl #(
    .CODE_LEN(CODE_LEN),
    .MAX_TRIES(MAX_TRIES),
    .LOCKOUT_CYC(LOCKOUT_CYC),
    .UNLOCK_CYC(UNLOCK_CYC),
    .RESET_CODE(16'h1234)
  ) dut (
    .clock(clock),
    .reset(reset),
    .newKey(newKey),
    .keyCode(keyCode),
    .switch(switch),
    .unlock(unlock),
    .eLED(eLED),
    .lockout(lockout),
    .dispVal(dispVal),
    .radixVal(radixVal)
  );

  always #100 clock = ~clock;

  function automatic expT lockedE(logic [15:0] dv, logic [3:0] rv);
    return {1'b0, 1'b0, 1'b0, dv, rv};
  endfunction
  function automatic expT setE(logic [15:0] dv, logic [3:0] rv);
    return {1'b1, 1'b0, 1'b0, dv, rv};
  endfunction
  function automatic expT openE();
    return {1'b1, 1'b0, 1'b0, 16'h0000, 4'hF};
  endfunction
  function automatic expT errE();
    return {1'b0, 1'b1, 1'b0, 16'hEEEE, 4'h0};
  endfunction
  function automatic expT lockoutE();
    return {1'b0, 1'b1, 1'b1, 16'hEEEE, 4'h0};
  endfunction

  function automatic void addVec(logic rst, logic nk, logic [4:0] kc, logic sw, expT e);
    vecT v;
    v.rst = rst;
    v.nk = nk;
    v.kc = kc;
    v.sw = sw;
    v.e = e;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput();
    expT act;
    expT want;
    act = {unlock, eLED, lockout, dispVal, radixVal};
    compared++;
    if (expQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL step %0d: scoreboard empty, got %h", stepId, act);
    end else begin
      want = expQ.pop_front();
      if (act !== want) begin
        mismatched++;
        $display("[TB] FAIL step %0d unlock/eLED/lockout/dispVal/radixVal: got %b/%b/%b/%h/%h want %b/%b/%b/%h/%h",
                 stepId, act.u, act.e, act.lo, act.dv, act.rv, want.u, want.e, want.lo, want.dv, want.rv);
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic nk, input logic [4:0] kc, input logic sw, input expT e);
    @(negedge clock);
    reset = rst;
    newKey = nk;
    keyCode = kc;
    switch = sw;
    stepId++;
    expQ.push_back(e);
    @(posedge clock);
    #1;
    checkOutput();
  endtask

  task automatic press(input logic [4:0] kc, input expT e);
    applyStimulus(1'b0, 1'b1, kc, 1'b1, e);
  endtask

  task automatic idle(input logic sw, input expT e);
    applyStimulus(1'b0, 1'b0, 5'h00, sw, e);
  endtask

  task automatic unlockDefault();
    press(5'h01, lockedE(16'h0001, 4'h1));
    press(5'h02, lockedE(16'h0012, 4'h3));
    press(5'h03, lockedE(16'h0123, 4'h7));
    press(5'h04, lockedE(16'h1234, 4'hF));
    press(K_ENTER, openE());
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    newKey = 1'b0;
    keyCode = 5'h00;
    switch = 1'b1;

    addVec(1, 0, 5'h00, 1, lockedE(16'h0000, 4'h0));
    addVec(1, 0, 5'h00, 1, lockedE(16'h0000, 4'h0));
    addVec(0, 1, 5'h01, 1, lockedE(16'h0001, 4'h1));
    addVec(0, 1, 5'h02, 1, lockedE(16'h0012, 4'h3));
    addVec(0, 1, 5'h03, 1, lockedE(16'h0123, 4'h7));
    addVec(0, 0, 5'h00, 1, lockedE(16'h0123, 4'h7));
    addVec(0, 1, 5'h04, 1, lockedE(16'h1234, 4'hF));
    addVec(0, 1, 5'h05, 1, lockedE(16'h1234, 4'hF));
    addVec(0, 1, K_ENTER, 1, openE());
    addVec(0, 0, 5'h00, 1, openE());
    addVec(0, 1, K_ENTER, 1, lockedE(16'h0000, 4'h0));
    addVec(0, 1, 5'h01, 1, lockedE(16'h0001, 4'h1));
    addVec(0, 1, 5'h02, 1, lockedE(16'h0012, 4'h3));
    addVec(0, 1, K_ENTER, 1, errE());
    addVec(0, 0, 5'h00, 1, errE());
    addVec(0, 1, 5'h1F, 1, lockedE(16'h0000, 4'h0));
    addVec(0, 1, 5'h0A, 1, lockedE(16'h000A, 4'h1));
    addVec(0, 1, K_CLEAR, 1, lockedE(16'h0000, 4'h0));
    addVec(0, 1, K_ENTER, 1, errE());
    addVec(0, 1, 5'h07, 1, lockedE(16'h0000, 4'h0));
    addVec(0, 1, 5'h01, 1, lockedE(16'h0001, 4'h1));
    addVec(0, 1, 5'h02, 1, lockedE(16'h0012, 4'h3));
    addVec(0, 1, 5'h03, 1, lockedE(16'h0123, 4'h7));
    addVec(0, 1, 5'h05, 1, lockedE(16'h1235, 4'hF));
    addVec(0, 1, K_ENTER, 1, lockoutE());
    for (int j = 1; j < LOCKOUT_CYC; j++)
      addVec(0, 1, (j % 2 == 1) ? 5'h01 : K_ENTER, 1, lockoutE());
    addVec(0, 1, 5'h01, 1, lockedE(16'h0000, 4'h0));
    addVec(0, 1, K_ENTER, 1, errE());
    addVec(0, 1, 5'h03, 1, lockedE(16'h0000, 4'h0));

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i].rst, vecs[i].nk, vecs[i].kc, vecs[i].sw, vecs[i].e);

    // Reset while locked out, then the default code must open again.
    press(K_ENTER, errE());
    press(5'h00, lockedE(16'h0000, 4'h0));
    press(K_ENTER, lockoutE());
    for (int j = 0; j < 3; j++) idle(1'b1, lockoutE());
    applyStimulus(1'b1, 1'b0, 5'h00, 1'b1, lockedE(16'h0000, 4'h0));
    unlockDefault();
    press(K_ENTER, lockedE(16'h0000, 4'h0));

    // Door open longer than the relock timeout; closing it relocks.
    unlockDefault();
    press(5'h03, openE());
    for (int j = 0; j < 3; j++) idle(1'b0, openE());
    applyStimulus(1'b0, 1'b1, K_ENTER, 1'b0, openE());
    for (int j = 0; j < UNLOCK_CYC; j++) idle(1'b0, openE());
    idle(1'b1, lockedE(16'h0000, 4'h0));

    // Door never opened: relock after UNLOCK_CYC cycles.
    unlockDefault();
    for (int j = 1; j < UNLOCK_CYC; j++) idle(1'b1, openE());
    idle(1'b1, lockedE(16'h0000, 4'h0));

    // Door opens in the very cycle the timer expires: stays open.
    unlockDefault();
    for (int j = 1; j < UNLOCK_CYC; j++) idle(1'b1, openE());
    idle(1'b0, openE());
    idle(1'b0, openE());
    idle(1'b1, lockedE(16'h0000, 4'h0));

`ifdef COMBLOCK_SETCODE_EN
    unlockDefault();
    press(K_SET, setE(16'h0000, 4'h0));
    press(5'h09, setE(16'h0009, 4'h1));
    press(5'h08, setE(16'h0098, 4'h3));
    press(5'h07, setE(16'h0987, 4'h7));
    press(K_ENTER, setE(16'h0987, 4'h7));
    press(5'h06, setE(16'h9876, 4'hF));
    press(5'h05, setE(16'h9876, 4'hF));
    press(K_ENTER, openE());
    press(K_ENTER, lockedE(16'h0000, 4'h0));
    press(5'h01, lockedE(16'h0001, 4'h1));
    press(5'h02, lockedE(16'h0012, 4'h3));
    press(5'h03, lockedE(16'h0123, 4'h7));
    press(5'h04, lockedE(16'h1234, 4'hF));
    press(K_ENTER, errE());
    press(5'h00, lockedE(16'h0000, 4'h0));
    press(5'h09, lockedE(16'h0009, 4'h1));
    press(5'h08, lockedE(16'h0098, 4'h3));
    press(5'h07, lockedE(16'h0987, 4'h7));
    press(5'h06, lockedE(16'h9876, 4'hF));
    press(K_ENTER, openE());
    press(K_SET, setE(16'h0000, 4'h0));
    press(5'h01, setE(16'h0001, 4'h1));
    press(K_CLEAR, setE(16'h0000, 4'h0));
    press(5'h02, setE(16'h0002, 4'h1));
    press(K_SET, openE());
    idle(1'b0, openE());
    applyStimulus(1'b0, 1'b1, K_SET, 1'b1, lockedE(16'h0000, 4'h0));
    press(5'h09, lockedE(16'h0009, 4'h1));
    press(5'h08, lockedE(16'h0098, 4'h3));
    press(5'h07, lockedE(16'h0987, 4'h7));
    press(5'h06, lockedE(16'h9876, 4'hF));
    press(K_ENTER, openE());
    press(K_SET, setE(16'h0000, 4'h0));
    press(5'h01, setE(16'h0001, 4'h1));
    applyStimulus(1'b1, 1'b0, 5'h00, 1'b1, lockedE(16'h0000, 4'h0));
    unlockDefault();
    press(K_ENTER, lockedE(16'h0000, 4'h0));
`else
    press(K_SET, lockedE(16'h0000, 4'h0));
    unlockDefault();
    press(K_SET, openE());
    press(K_ENTER, lockedE(16'h0000, 4'h0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
